serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor that computes diff = a - b - bin. It processes one bit per clock, LSB first, through a single full-subtractor cell. It is the inverse-operation companion to the team's combinational full adder: it reuses one 1-bit cell over WIDTH cycles instead of a ripple array. It sits behind a start/done handshake so a bench or controller can issue operations back to back.

Parameters:
- WIDTH, 8, operand and result width in bits (must be >= 2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous, active-high
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  minuend; captured on the accepted start edge
- b  input  WIDTH  subtrahend; captured on the accepted start edge
- bin  input  1  borrow-in; captured on the accepted start edge
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when diff/bout are updated
- diff  output  WIDTH  result; holds the last completed value
- bout  output  1  borrow out of the MSB for the last completed operation
- ovf  output  1  only with SIGNED_OVF_EN (see Optional Feature)

Behaviour:
Reset:
- rst=1 at a clock edge forces state=IDLE, busy=0, done=0, diff=0, bout=0, ovf=0.
- All internal shift registers, the bit counter and the running borrow clear to 0.
- rst takes priority over every other input.

FSM states: IDLE, SHIFT, DONE.
- IDLE: start=1 latches a, b, bin into internal registers, clears the counter, sets busy=1 and moves to SHIFT. start=0 stays in IDLE.
- SHIFT, one bit per edge, using a0/b0 as the current LSBs of the shifted operands and br as the running borrow:
  - d = a0 ^ b0 ^ br
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
  - d shifts into the MSB of the result shift register; the operand registers shift right; the counter increments.
  - start is ignored in SHIFT.
- After the edge that processes bit WIDTH-1: diff <= result register, bout <= br_next, done=1, busy=0, state=DONE.
- DONE, lasts exactly one cycle:
  - done=1 during this cycle.
  - Next edge with start=0: go to IDLE, done=0.
  - Next edge with start=1: accept new operands exactly as IDLE does (busy=1, done=0, go to SHIFT). Back-to-back operations therefore have no idle gap.

Latency:
- Edge 0 accepts start.
- Edges 1..WIDTH process bits 0..WIDTH-1.
- done is high in the cycle following edge WIDTH.
- Throughput is one operation per WIDTH+1 cycles.

Output stability:
- diff and bout change only on the completion edge and hold through later operations until the next completion.
- Intermediate shift contents are never visible on diff.

Arithmetic:
- The result is modulo 2^WIDTH.
- bout=1 iff unsigned a < b + bin.

Reset mid-operation:
- The operation is aborted; no done pulse is produced; outputs take their reset values.

Optional Feature:
Macro SIGNED_OVF_EN.
- Defined:
  - Port ovf exists.
  - On the completion edge, ovf <= (borrow into the MSB) ^ (borrow out of the MSB), i.e. two's-complement overflow of a - b - bin.
  - ovf holds like diff and resets to 0.
- Undefined: port ovf and its logic are absent; all other behaviour is identical.

Test Plan:
All scenarios use WIDTH=8.
1. a=8'd10, b=8'd3, bin=0, start pulsed one cycle -> busy high 8 cycles, then done=1 for one cycle with diff=8'h07, bout=0.
2. a=8'd3, b=8'd10, bin=0 -> diff=8'hF9, bout=1. Boundary a=8'hFF, b=8'hFF, bin=0 -> diff=8'h00, bout=0.
3. a=0, b=0, bin=1 -> diff=8'hFF, bout=1. Then a=8'h80, b=0, bin=1 -> diff=8'h7F, bout=0.
4. Scenario 1 completes; start held high during SHIFT with new operands a=1, b=1 -> they are ignored; diff stays 8'h07 until done; no extra done pulse. Then reset at the 4th SHIFT edge of a fresh op -> busy=0, done never asserts, diff=0, bout=0.
5. start=1 in the DONE cycle with a=8'd5, b=8'd2 -> busy reasserts on the next edge with no IDLE cycle; second done arrives 9 cycles after the first with diff=8'h03.
6. SIGNED_OVF_EN defined:
   - a=8'h80, b=8'h01, bin=0 -> diff=8'h7F, ovf=1.
   - a=8'h7F, b=8'hFF, bin=0 -> diff=8'h80, ovf=1.
   - a=8'h05, b=8'h03, bin=0 -> diff=8'h02, ovf=0.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Handshake and result bundle for serial_subtractor.
// With SIGNED_OVF_EN defined the bundle also carries the ovf flag.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SIGNED_OVF_EN
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf
    );
`else
    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, one full-subtractor step per clock, LSB first.
// Optional macro SIGNED_OVF_EN adds ovf (two's-complement overflow of the last completed result).
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_subtractor_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic             br;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             last_bit;
    logic             d_bit;
    logic             br_next;

    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
`ifdef SIGNED_OVF_EN
    logic             ovf_q;
`endif

    // Single full-subtractor cell applied to the current operand LSBs
    always_comb begin
        d_bit   = a_sh[0] ^ b_sh[0] ^ br;
        br_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    end

    // res_sh keeps only the WIDTH-1 settled bits; the final bit joins on the completion edge
    assign res_next = {d_bit, res_sh};
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
`ifdef SIGNED_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else if (accept) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            br     <= bus.bin;
            res_sh <= '0;
            cnt    <= '0;
        end else if (state == SHIFT) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_next[WIDTH-1:1];
            br     <= br_next;
            cnt    <= cnt + 1'b1;
            if (last_bit) begin
                diff_q <= res_next;
                bout_q <= br_next;
`ifdef SIGNED_OVF_EN
                // br is the borrow into the MSB while the MSB is being processed
                ovf_q  <= br ^ br_next;
`endif
            end
        end
    end

    assign bus.busy = (state == SHIFT);
    assign bus.done = (state == DONE);
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
`ifdef SIGNED_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus $urandom operations
// checked against an arithmetic reference model (ovf checked when SIGNED_OVF_EN is defined).
module tb_serial_subtractor;
    localparam int unsigned WIDTH = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [WIDTH-1:0] exp_diff = '0;
    logic             exp_bout = 1'b0;
    logic             exp_ovf  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands
    function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic bi, output logic [WIDTH-1:0] d,
                                  output logic bo, output logic ov);
        int sr;
        d  = WIDTH'(int'(a) - int'(b) - int'(bi));
        bo = (int'(a) < (int'(b) + int'(bi)));
        sr = int'($signed(a)) - int'($signed(b)) - int'(bi);
        ov = (sr < -(1 <<< (WIDTH - 1))) || (sr > ((1 <<< (WIDTH - 1)) - 1));
    endfunction

    task automatic chk_outputs(input string tag);
        chk({tag, "_diff"}, 32'(bus.diff), 32'(exp_diff));
        chk({tag, "_bout"}, 32'(bus.bout), 32'(exp_bout));
`ifdef SIGNED_OVF_EN
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
`endif
    endtask

    // Cursor convention: every task is entered and left #1 after a rising edge
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bi);
        bus.a     = a;
        bus.b     = b;
        bus.bin   = bi;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("accept_busy", 32'(bus.busy), 32'd1);
        chk("accept_done", 32'(bus.done), 32'd0);
    endtask

    task automatic finish_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic bi, input bit hold);
        int unsigned cyc = 0;
        logic [WIDTH-1:0] md;
        logic mb;
        logic mo;
        if (hold) begin
            bus.start = 1'b1;
            bus.a     = 1;
            bus.b     = 1;
            bus.bin   = 1'b0;
        end
        while (bus.done !== 1'b1 && cyc < 4 * WIDTH) begin
            chk("busy_in_shift", 32'(bus.busy), 32'd1);
            chk("diff_stable", 32'(bus.diff), 32'(exp_diff));
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.start = 1'b0;
        chk("latency", cyc, WIDTH);
        model(a, b, bi, md, mb, mo);
        exp_diff = md;
        exp_bout = mb;
        exp_ovf  = mo;
        chk_outputs("result");
        chk("busy_at_done", 32'(bus.busy), 32'd0);
    endtask

    task automatic idle_step();
        @(posedge clk);
        #1;
        chk("idle_done", 32'(bus.done), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk_outputs("idle_hold");
    endtask

    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bi);
        start_op(a, b, bi);
        finish_op(a, b, bi, 1'b0);
        idle_step();
    endtask

    initial begin
        int unsigned seen;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic rbi;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk_outputs("reset");
        rst = 1'b0;
        idle_step();

        // Basic, negative result, all-ones, borrow-in cases
        do_op(8'd10, 8'd3, 1'b0);
        do_op(8'd3, 8'd10, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b0);
        do_op(8'h00, 8'h00, 1'b1);
        do_op(8'h80, 8'h00, 1'b1);

        // Signed overflow vectors
        do_op(8'h80, 8'h01, 1'b0);
        do_op(8'h7F, 8'hFF, 1'b0);
        do_op(8'h05, 8'h03, 1'b0);

        // start held high with new operands during SHIFT is ignored
        start_op(8'd10, 8'd3, 1'b0);
        finish_op(8'd10, 8'd3, 1'b0, 1'b1);
        idle_step();
        idle_step();

        // Back-to-back: second start issued in the DONE cycle
        start_op(8'd10, 8'd3, 1'b0);
        finish_op(8'd10, 8'd3, 1'b0, 1'b0);
        start_op(8'd5, 8'd2, 1'b0);
        finish_op(8'd5, 8'd2, 1'b0, 1'b0);
        idle_step();

        // Reset on the 4th SHIFT edge aborts the operation
        start_op(8'h55, 8'h22, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_diff = '0;
        exp_bout = 1'b0;
        exp_ovf  = 1'b0;
        chk("midreset_busy", 32'(bus.busy), 32'd0);
        chk("midreset_done", 32'(bus.done), 32'd0);
        chk_outputs("midreset");
        seen = 0;
        repeat (WIDTH + 3) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
        end
        chk("no_done_after_reset", seen, 0);
        chk_outputs("after_abort");

        // Random operations, randomly chained back to back
        for (int i = 0; i < 40; i++) begin
            ra  = WIDTH'($urandom);
            rb  = WIDTH'($urandom);
            rbi = 1'($urandom_range(1));
            start_op(ra, rb, rbi);
            finish_op(ra, rb, rbi, bit'($urandom_range(3) == 0));
            if (i == 39 || $urandom_range(1) == 0) idle_step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
